// File: rtl/rob_pkg.sv
// rob_pkg: shared widths, instruction type codes and temp-file entry layout for the ROB storage
package rob_pkg;
   localparam int TAG_W = 5;
   localparam int REG_W = 5;
   localparam int DATA_W = 32;
   localparam int DEPTH = 1 << TAG_W;
   localparam int NREG = 1 << REG_W;
   typedef enum logic [1:0] {
      T_RD = 2'b00,
      T_BR = 2'b01,
      T_ST = 2'b10
   } inst_type_t;
   typedef struct packed {
      logic [REG_W-1:0]  rd_reg;
      logic [DATA_W-1:0] pc;
      inst_type_t        itype;
      logic [DATA_W-1:0] spec_data;
      logic              spec_valid;
      logic              valid;
   } rft_entry_t;
endpackage

// File: rtl/rob_state_store_if.sv
// rob_state_store_if: controller-facing bus of the ROB storage (queue, temp file, status table)
interface rob_state_store_if;
   import rob_pkg::*;
   logic              flush;
   logic              oq_push, oq_pop, oq_full, oq_empty;
   logic [TAG_W-1:0]  oq_push_tag, oq_head;
   logic [TAG_W:0]    oq_count;
   logic              rft_new, rft_upd;
   logic [TAG_W-1:0]  rft_waddr, rft_raddr1, rft_raddr2;
   rft_entry_t        rft_wdata, rft_rdata1, rft_rdata2;
   logic              rst_wen, rst_ret_valid, rst_rs_valid, rst_rt_valid;
   logic [REG_W-1:0]  rst_waddr, rst_rs_addr, rst_rt_addr;
   logic [TAG_W-1:0]  rst_wtag, rst_ret_tag, rst_rs_tag, rst_rt_tag;
   modport master (
      output flush, oq_push, oq_push_tag, oq_pop,
      output rft_new, rft_upd, rft_waddr, rft_wdata, rft_raddr1, rft_raddr2,
      output rst_wen, rst_waddr, rst_wtag, rst_rs_addr, rst_rt_addr, rst_ret_valid, rst_ret_tag,
      input  oq_head, oq_full, oq_empty, oq_count, rft_rdata1, rft_rdata2,
      input  rst_rs_tag, rst_rs_valid, rst_rt_tag, rst_rt_valid
   );
   modport slave (
      input  flush, oq_push, oq_push_tag, oq_pop,
      input  rft_new, rft_upd, rft_waddr, rft_wdata, rft_raddr1, rft_raddr2,
      input  rst_wen, rst_waddr, rst_wtag, rst_rs_addr, rst_rt_addr, rst_ret_valid, rst_ret_tag,
      output oq_head, oq_full, oq_empty, oq_count, rft_rdata1, rft_rdata2,
      output rst_rs_tag, rst_rs_valid, rst_rt_tag, rst_rt_valid
   );
endinterface

// File: rtl/rob_order_fifo.sv
// rob_order_fifo: circular program-order tag queue; pop frees a slot for a same-cycle push when full
module rob_order_fifo
   import rob_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [TAG_W-1:0] push_tag,
   input  logic             pop,
   output logic [TAG_W-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [TAG_W:0]   count
);
   logic [TAG_W-1:0] mem_q [DEPTH];
   logic [TAG_W-1:0] mem_d [DEPTH];
   logic [TAG_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [TAG_W:0]   cnt_q, cnt_d;
   logic             do_push, do_pop;
   assign full = cnt_q == (TAG_W+1)'(DEPTH);
   assign empty = cnt_q == '0;
   assign count = cnt_q;
   assign head = mem_q[rd_q];
   assign do_pop = pop && !empty && !flush;
   assign do_push = push && (!full || pop) && !flush;
   always_comb begin
      mem_d = mem_q;
      if (do_push) mem_d[wr_q] = push_tag;
      wr_d = flush ? '0 : do_push ? wr_q + TAG_W'(1) : wr_q;
      rd_d = flush ? '0 : do_pop ? rd_q + TAG_W'(1) : rd_q;
      cnt_d = flush ? '0 : cnt_q + (TAG_W+1)'(do_push) - (TAG_W+1)'(do_pop);
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_q <= '{default: '0};
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/rob_status_table.sv
// rob_status_table: arch-register to in-flight tag map; retire clears matching entries by CAM, a new mapping wins
module rob_status_table
   import rob_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             wen,
   input  logic [REG_W-1:0] waddr,
   input  logic [TAG_W-1:0] wtag,
   input  logic             ret_valid,
   input  logic [TAG_W-1:0] ret_tag,
   input  logic [REG_W-1:0] rs_addr,
   input  logic [REG_W-1:0] rt_addr,
   output logic [TAG_W-1:0] rs_tag,
   output logic             rs_valid,
   output logic [TAG_W-1:0] rt_tag,
   output logic             rt_valid
);
   logic [TAG_W-1:0] tag_q [NREG];
   logic [TAG_W-1:0] tag_d [NREG];
   logic [NREG-1:0]  valid_q, valid_d;
   assign rs_tag = tag_q[rs_addr];
   assign rs_valid = valid_q[rs_addr];
   assign rt_tag = tag_q[rt_addr];
   assign rt_valid = valid_q[rt_addr];
   always_comb begin
      tag_d = tag_q;
      valid_d = valid_q;
      if (flush) begin
         valid_d = '0;
      end else begin
         for (int i = 0; i < NREG; i++)
            if (ret_valid && valid_q[i] && tag_q[i] == ret_tag) valid_d[i] = 1'b0;
         if (wen) begin
            tag_d[waddr] = wtag;
            valid_d[waddr] = 1'b1;
         end
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tag_q <= '{default: '0};
         valid_q <= '0;
      end else begin
         tag_q <= tag_d;
         valid_q <= valid_d;
      end
   end
endmodule

// File: rtl/rob_tmp_regfile.sv
// rob_tmp_regfile: speculative result file indexed by tag; CDB updates touch only data and spec_valid
module rob_tmp_regfile
   import rob_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             new_en,
   input  logic             upd_en,
   input  logic [TAG_W-1:0] waddr,
   input  rft_entry_t       wdata,
   input  logic [TAG_W-1:0] raddr1,
   input  logic [TAG_W-1:0] raddr2,
   output rft_entry_t       rdata1,
   output rft_entry_t       rdata2
);
   rft_entry_t mem_q [DEPTH];
   rft_entry_t mem_d [DEPTH];
   assign rdata1 = mem_q[raddr1];
   assign rdata2 = mem_q[raddr2];
   always_comb begin
      mem_d = mem_q;
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_d[i].spec_valid = 1'b0;
            mem_d[i].valid = 1'b0;
         end
      end else if (new_en) begin
         mem_d[waddr] = wdata;
      end else if (upd_en) begin
         mem_d[waddr].spec_data = wdata.spec_data;
         mem_d[waddr].spec_valid = wdata.spec_valid;
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) mem_q <= '{default: '0};
      else mem_q <= mem_d;
   end
endmodule

// File: rtl/rob_state_store.sv
// rob_state_store: ROB storage back-end tying order queue, temp register file and status table to one bus
module rob_state_store
   import rob_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   rob_state_store_if.slave   bus
);
   rob_order_fifo u_fifo (
      .clock    (clock),
      .reset    (reset),
      .flush    (bus.flush),
      .push     (bus.oq_push),
      .push_tag (bus.oq_push_tag),
      .pop      (bus.oq_pop),
      .head     (bus.oq_head),
      .full     (bus.oq_full),
      .empty    (bus.oq_empty),
      .count    (bus.oq_count)
   );
   rob_tmp_regfile u_rft (
      .clock  (clock),
      .reset  (reset),
      .flush  (bus.flush),
      .new_en (bus.rft_new),
      .upd_en (bus.rft_upd),
      .waddr  (bus.rft_waddr),
      .wdata  (bus.rft_wdata),
      .raddr1 (bus.rft_raddr1),
      .raddr2 (bus.rft_raddr2),
      .rdata1 (bus.rft_rdata1),
      .rdata2 (bus.rft_rdata2)
   );
   rob_status_table u_rst (
      .clock     (clock),
      .reset     (reset),
      .flush     (bus.flush),
      .wen       (bus.rst_wen),
      .waddr     (bus.rst_waddr),
      .wtag      (bus.rst_wtag),
      .ret_valid (bus.rst_ret_valid),
      .ret_tag   (bus.rst_ret_tag),
      .rs_addr   (bus.rst_rs_addr),
      .rt_addr   (bus.rst_rt_addr),
      .rs_tag    (bus.rst_rs_tag),
      .rs_valid  (bus.rst_rs_valid),
      .rt_tag    (bus.rst_rt_tag),
      .rt_valid  (bus.rst_rt_valid)
   );
endmodule

// File: tb/tb_rob_state_store.sv
// tb_rob_state_store: directed stimulus checked against a queue/array model of the ROB storage rules
module tb_rob_state_store;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;
   logic [4:0]  mq [$];
   logic [72:0] m_tmp [32];
   logic [4:0]  m_tag [32];
   bit          m_val [32];
   rob_state_store_if bus();
   rob_state_store dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );
   always #5 clock = ~clock;
   task automatic chk(input string n, input logic [79:0] a, input logic [79:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask
   task automatic m_reset();
      mq.delete();
      for (int i = 0; i < 32; i++) begin
         m_tmp[i] = '0;
         m_tag[i] = '0;
         m_val[i] = 0;
      end
   endtask
   task automatic m_step();
      int n;
      bit po, pu;
      logic [72:0] w;
      n = mq.size();
      po = bus.oq_pop && n > 0;
      pu = bus.oq_push && (n < 32 || bus.oq_pop);
      w = bus.rft_wdata;
      if (bus.flush) begin
         mq.delete();
         for (int i = 0; i < 32; i++) begin
            m_tmp[i][1:0] = 2'b00;
            m_val[i] = 0;
         end
      end else begin
         if (po) void'(mq.pop_front());
         if (pu) mq.push_back(bus.oq_push_tag);
         if (bus.rft_new) m_tmp[bus.rft_waddr] = w;
         else if (bus.rft_upd) m_tmp[bus.rft_waddr][33:1] = w[33:1];
         if (bus.rst_ret_valid)
            for (int i = 0; i < 32; i++)
               if (m_val[i] && m_tag[i] == bus.rst_ret_tag) m_val[i] = 0;
         if (bus.rst_wen) begin
            m_tag[bus.rst_waddr] = bus.rst_wtag;
            m_val[bus.rst_waddr] = 1;
         end
      end
   endtask
   initial forever begin
      @(posedge clock);
      if (!reset) m_step();
   end
   initial forever begin
      @(negedge clock);
      chk("count", 80'(bus.oq_count), 80'(mq.size()));
      chk("empty", 80'(bus.oq_empty), 80'(mq.size() == 0));
      chk("full", 80'(bus.oq_full), 80'(mq.size() == 32));
      if (mq.size() > 0) chk("head", 80'(bus.oq_head), 80'(mq[0]));
      chk("rdata1", 80'(bus.rft_rdata1), 80'(m_tmp[bus.rft_raddr1]));
      chk("rdata2", 80'(bus.rft_rdata2), 80'(m_tmp[bus.rft_raddr2]));
      chk("rs_tag", 80'(bus.rst_rs_tag), 80'(m_tag[bus.rst_rs_addr]));
      chk("rs_valid", 80'(bus.rst_rs_valid), 80'(m_val[bus.rst_rs_addr]));
      chk("rt_tag", 80'(bus.rst_rt_tag), 80'(m_tag[bus.rst_rt_addr]));
      chk("rt_valid", 80'(bus.rst_rt_valid), 80'(m_val[bus.rst_rt_addr]));
   end
   task automatic tick();
      @(posedge clock);
      #1;
      bus.flush = 0;
      bus.oq_push = 0;
      bus.oq_pop = 0;
      bus.rft_new = 0;
      bus.rft_upd = 0;
      bus.rst_wen = 0;
      bus.rst_ret_valid = 0;
   endtask
   task automatic push(input logic [4:0] t, input bit p);
      bus.oq_push = 1;
      bus.oq_push_tag = t;
      bus.oq_pop = p;
      tick();
   endtask
   task automatic pop();
      bus.oq_pop = 1;
      tick();
   endtask
   initial begin
      bus.flush = 0; bus.oq_push = 0; bus.oq_pop = 0; bus.oq_push_tag = 0;
      bus.rft_new = 0; bus.rft_upd = 0; bus.rft_waddr = 0; bus.rft_wdata = '0;
      bus.rft_raddr1 = 0; bus.rft_raddr2 = 0;
      bus.rst_wen = 0; bus.rst_waddr = 0; bus.rst_wtag = 0;
      bus.rst_ret_valid = 0; bus.rst_ret_tag = 0; bus.rst_rs_addr = 0; bus.rst_rt_addr = 0;
      m_reset();
      tick();
      tick();
      chk("rst_head", 80'(bus.oq_head), 80'(0));
      chk("rst_empty", 80'(bus.oq_empty), 80'(1));
      chk("rst_rdata", 80'(bus.rft_rdata1), 80'(0));
      reset = 0;
      tick();
      push(5'd3, 0); push(5'd7, 0); push(5'd9, 0); pop();
      chk("head_7", 80'(bus.oq_head), 80'(7));
      chk("count_2", 80'(bus.oq_count), 80'(2));
      bus.flush = 1;
      tick();
      for (int i = 0; i < 32; i++) push(5'(i * 7 + 1), 0);
      chk("full_32", 80'(bus.oq_full), 80'(1));
      push(5'd5, 0);
      chk("drop_33rd", 80'(bus.oq_count), 80'(32));
      push(5'd20, 1);
      chk("pp_full_cnt", 80'(bus.oq_count), 80'(32));
      chk("pp_full_head", 80'(bus.oq_head), 80'(8));
      for (int i = 0; i < 31; i++) pop();
      chk("tail_20", 80'(bus.oq_head), 80'(20));
      bus.rft_raddr1 = 4;
      bus.rft_waddr = 4;
      bus.rft_new = 1;
      bus.rft_wdata = {5'd3, 32'h1000, 2'b00, 32'h0, 1'b0, 1'b1};
      tick();
      bus.rft_upd = 1;
      bus.rft_wdata = {5'd31, 32'hFFFF, 2'b10, 32'hDEADBEEF, 1'b1, 1'b0};
      tick();
      chk("upd_data", 80'(bus.rft_rdata1[33:1]), 80'({32'hDEADBEEF, 1'b1}));
      chk("upd_pc", 80'(bus.rft_rdata1[67:36]), 80'(32'h1000));
      chk("upd_valid", 80'(bus.rft_rdata1[0]), 80'(1));
      bus.rft_raddr2 = 9;
      bus.rft_waddr = 9;
      bus.rft_new = 1;
      bus.rft_upd = 1;
      bus.rft_wdata = {5'd2, 32'hABCD, 2'b01, 32'h1234, 1'b0, 1'b1};
      tick();
      chk("new_wins", 80'(bus.rft_rdata2), 80'({5'd2, 32'hABCD, 2'b01, 32'h1234, 1'b0, 1'b1}));
      bus.rst_rs_addr = 5;
      bus.rst_wen = 1; bus.rst_waddr = 5; bus.rst_wtag = 12;
      tick();
      chk("rs_map", 80'({bus.rst_rs_valid, bus.rst_rs_tag}), 80'({1'b1, 5'd12}));
      bus.rst_ret_valid = 1; bus.rst_ret_tag = 12;
      tick();
      chk("rs_retired", 80'(bus.rst_rs_valid), 80'(0));
      bus.rst_rt_addr = 6;
      bus.rst_wen = 1; bus.rst_waddr = 6; bus.rst_wtag = 12;
      bus.rst_ret_valid = 1; bus.rst_ret_tag = 12;
      tick();
      chk("write_wins", 80'(bus.rst_rt_valid), 80'(1));
      bus.rst_rs_addr = 0;
      bus.rst_wen = 1; bus.rst_waddr = 0; bus.rst_wtag = 21;
      tick();
      chk("reg0", 80'({bus.rst_rs_valid, bus.rst_rs_tag}), 80'({1'b1, 5'd21}));
      for (int i = 0; i < 10; i++) begin
         bus.rft_new = 1; bus.rft_waddr = 5'(i);
         bus.rft_wdata = {5'(i), 32'(i * 16), 2'b00, 32'(i), 1'b1, 1'b1};
         bus.rst_wen = 1; bus.rst_waddr = 5'(i + 10); bus.rst_wtag = 5'(i);
         push(5'(i + 2), 0);
      end
      bus.flush = 1;
      bus.oq_push = 1; bus.oq_push_tag = 1;
      bus.rst_wen = 1; bus.rst_waddr = 7; bus.rst_wtag = 3;
      bus.rft_new = 1; bus.rft_waddr = 2; bus.rft_wdata = '1;
      tick();
      chk("flush_empty", 80'(bus.oq_empty), 80'(1));
      chk("flush_count", 80'(bus.oq_count), 80'(0));
      for (int i = 0; i < 32; i++) begin
         bus.rst_rs_addr = 5'(i);
         bus.rft_raddr1 = 5'(i);
         #1;
         chk("flush_rs_valid", 80'(bus.rst_rs_valid), 80'(0));
         chk("flush_rft_v", 80'(bus.rft_rdata1[1:0]), 80'(0));
      end
      bus.rft_raddr1 = 2;
      #1;
      chk("flush_rft_keep", 80'(bus.rft_rdata1[72:2]), 80'({5'd2, 32'd32, 2'b00, 32'd2}));
      tick();
      push(5'd17, 0);
      for (int i = 0; i < 40; i++) push(5'((i + 1) * 3), 1);
      chk("wrap_head", 80'(bus.oq_head), 80'(24));
      chk("wrap_count", 80'(bus.oq_count), 80'(1));
      push(5'd4, 0);
      #2;
      reset = 1;
      m_reset();
      #1;
      chk("async_count", 80'(bus.oq_count), 80'(0));
      chk("async_head", 80'(bus.oq_head), 80'(0));
      chk("async_rt", 80'(bus.rst_rt_valid), 80'(0));
      tick();
      reset = 0;
      tick();
      push(5'd11, 0);
      chk("post_reset", 80'(bus.oq_head), 80'(11));
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
